// File: rtl/intm_rs_pkg.sv
// Shared types for the integer mul/div reservation station: widths, opcodes,
// the dispatched entry and the issue-register payload.
package intm_rs_pkg;

   localparam int unsigned PHY_REG_W  = 6;
   localparam int unsigned ROB_ID_W   = 5;
   localparam int unsigned ARCH_REG_W = 5;
   localparam int unsigned XLEN       = 32;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef struct packed {
      logic [ROB_ID_W-1:0]   rob_id;
      logic [ARCH_REG_W-1:0] rd_arch;
      logic [PHY_REG_W-1:0]  rd_phy;
      logic [PHY_REG_W-1:0]  rs1_phy;
      logic                  rs1_rdy;
      logic [PHY_REG_W-1:0]  rs2_phy;
      logic                  rs2_rdy;
      md_op_e                fu_opcode;
   } intm_rs_entry_t;

   typedef struct packed {
      logic [ROB_ID_W-1:0]   rob_id;
      logic [ARCH_REG_W-1:0] rd_arch;
      logic [PHY_REG_W-1:0]  rd_phy;
      logic [XLEN-1:0]       rs1_value;
      logic [XLEN-1:0]       rs2_value;
      md_op_e                fu_opcode;
   } intm_rs_reg_t;

endpackage

// File: rtl/intm_rs_if.sv
// Dispatch, CDB snoop, PRF read and FU issue signals of intm_rs.
// INTM_RS_PERF_EN adds the performance counter outputs.
interface intm_rs_if #(
   parameter int unsigned CDB_WIDTH = 3
);
   import intm_rs_pkg::*;

   logic                           flush;
   logic                           dis_valid;
   logic                           dis_ready;
   intm_rs_entry_t                 dis_uop;
   logic [CDB_WIDTH-1:0]           cdb_valid;
   logic [CDB_WIDTH*PHY_REG_W-1:0] cdb_rd_phy;
   logic [PHY_REG_W-1:0]           prf_rs1_phy;
   logic [PHY_REG_W-1:0]           prf_rs2_phy;
   logic [XLEN-1:0]                prf_rs1_value;
   logic [XLEN-1:0]                prf_rs2_value;
   logic                           nxt_valid;
   logic                           nxt_ready;
   intm_rs_reg_t                   intm_rs_out;
   logic                           full;
`ifdef INTM_RS_PERF_EN
   logic [31:0]                    perf_full_cycles;
   logic [31:0]                    perf_issued;
   logic [31:0]                    perf_stall_cycles;

   modport master (
      output flush, dis_valid, dis_uop, cdb_valid, cdb_rd_phy,
             prf_rs1_value, prf_rs2_value, nxt_ready,
      input  dis_ready, prf_rs1_phy, prf_rs2_phy, nxt_valid, intm_rs_out, full,
             perf_full_cycles, perf_issued, perf_stall_cycles
   );

   modport slave (
      input  flush, dis_valid, dis_uop, cdb_valid, cdb_rd_phy,
             prf_rs1_value, prf_rs2_value, nxt_ready,
      output dis_ready, prf_rs1_phy, prf_rs2_phy, nxt_valid, intm_rs_out, full,
             perf_full_cycles, perf_issued, perf_stall_cycles
   );
`else
   modport master (
      output flush, dis_valid, dis_uop, cdb_valid, cdb_rd_phy,
             prf_rs1_value, prf_rs2_value, nxt_ready,
      input  dis_ready, prf_rs1_phy, prf_rs2_phy, nxt_valid, intm_rs_out, full
   );

   modport slave (
      input  flush, dis_valid, dis_uop, cdb_valid, cdb_rd_phy,
             prf_rs1_value, prf_rs2_value, nxt_ready,
      output dis_ready, prf_rs1_phy, prf_rs2_phy, nxt_valid, intm_rs_out, full
   );
`endif

endinterface

// File: rtl/intm_rs_select.sv
// Combinational lowest-index picker: one-hot grant, binary index and found flag.
module intm_rs_select #(
   parameter  int unsigned N     = 4,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Scan from the top so the lowest requesting index is written last.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = IDX_W'(i);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/intm_rs.sv
// Integer mul/div reservation station: collapsing age-ordered queue with CDB
// wakeup, oldest-ready select and a registered issue stage. Optional macro
// INTM_RS_PERF_EN adds saturating performance counters.
module intm_rs
   import intm_rs_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 4,
   parameter int unsigned CDB_WIDTH   = 3
) (
   input logic    clk,
   input logic    rst,
   intm_rs_if.slave bus
);

   localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

   intm_rs_entry_t             ent_q   [NUM_ENTRIES];
   intm_rs_entry_t             ent_d   [NUM_ENTRIES];
   intm_rs_entry_t             ent_ext [NUM_ENTRIES+1];
   logic [NUM_ENTRIES-1:0]     valid_q;
   logic [NUM_ENTRIES-1:0]     valid_d;
   logic [NUM_ENTRIES:0]       val_ext;
   logic                       nxt_valid_q;
   intm_rs_reg_t               out_q;

   logic [NUM_ENTRIES-1:0]     ready_vec;
   logic [NUM_ENTRIES-1:0]     req;
   logic [NUM_ENTRIES-1:0]     grant;
   logic [IDX_W-1:0]           sel_idx;
   logic                       sel_found;
   intm_rs_entry_t             sel_e;
   intm_rs_entry_t             dis_w;
   logic                       issue_adv;
   logic                       do_issue;
   logic                       accept;
   logic [CNT_W-1:0]           cnt;
   logic [CNT_W-1:0]           cnt_after;

   // Sets a source ready when it is phy 0 or any CDB port broadcasts it.
   function automatic intm_rs_entry_t wake(
      input intm_rs_entry_t                 e,
      input logic [CDB_WIDTH-1:0]           v,
      input logic [CDB_WIDTH*PHY_REG_W-1:0] p
   );
      intm_rs_entry_t r;
      r = e;
      for (int k = 0; k < CDB_WIDTH; k++) begin
         if (v[k] && (p[k*PHY_REG_W +: PHY_REG_W] == e.rs1_phy)) r.rs1_rdy = 1'b1;
         if (v[k] && (p[k*PHY_REG_W +: PHY_REG_W] == e.rs2_phy)) r.rs2_rdy = 1'b1;
      end
      if (e.rs1_phy == '0) r.rs1_rdy = 1'b1;
      if (e.rs2_phy == '0) r.rs2_rdy = 1'b1;
      return r;
   endfunction

   assign issue_adv = ~nxt_valid_q | bus.nxt_ready;
   assign dis_w     = wake(bus.dis_uop, bus.cdb_valid, bus.cdb_rd_phy);

   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         ready_vec[i] = valid_q[i] & ent_q[i].rs1_rdy & ent_q[i].rs2_rdy;
      end
      req = issue_adv ? ready_vec : '0;
   end

   intm_rs_select #(.N(NUM_ENTRIES)) u_select (
      .req   (req),
      .grant (grant),
      .idx   (sel_idx),
      .found (sel_found)
   );

   // One-hot mux of the granted entry; all-zero when nothing is selected.
   always_comb begin
      sel_e = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (grant[i]) sel_e = ent_q[i];
      end
   end

   assign bus.prf_rs1_phy = sel_e.rs1_rdy ? sel_e.rs1_phy : '0;
   assign bus.prf_rs2_phy = sel_e.rs2_rdy ? sel_e.rs2_phy : '0;

   assign do_issue = sel_found & ~bus.flush;
   assign accept   = bus.dis_valid & ~valid_q[NUM_ENTRIES-1] & ~bus.flush;

   always_comb begin
      cnt = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         cnt = cnt + CNT_W'(valid_q[i]);
      end
      cnt_after = cnt - CNT_W'(do_issue);
   end

   // Collapse above the issued slot, wake survivors, then append the new uop.
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         ent_ext[i] = ent_q[i];
         val_ext[i] = valid_q[i];
      end
      ent_ext[NUM_ENTRIES] = '0;
      val_ext[NUM_ENTRIES] = 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (do_issue && (IDX_W'(i) >= sel_idx)) begin
            ent_d[i]   = wake(ent_ext[i+1], bus.cdb_valid, bus.cdb_rd_phy);
            valid_d[i] = val_ext[i+1];
         end else begin
            ent_d[i]   = wake(ent_ext[i], bus.cdb_valid, bus.cdb_rd_phy);
            valid_d[i] = val_ext[i];
         end
         if (accept && (CNT_W'(i) == cnt_after)) begin
            ent_d[i]   = dis_w;
            valid_d[i] = 1'b1;
         end
      end
      if (bus.flush) valid_d = '0;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         ent_q[i] <= ent_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= '0;
         nxt_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         valid_q <= valid_d;
         if (bus.flush) begin
            nxt_valid_q <= 1'b0;
         end else if (issue_adv) begin
            nxt_valid_q <= sel_found;
         end
         if (do_issue) begin
            out_q <= '{rob_id:    sel_e.rob_id,
                       rd_arch:   sel_e.rd_arch,
                       rd_phy:    sel_e.rd_phy,
                       rs1_value: bus.prf_rs1_value,
                       rs2_value: bus.prf_rs2_value,
                       fu_opcode: sel_e.fu_opcode};
         end
      end
   end

   assign bus.dis_ready   = ~valid_q[NUM_ENTRIES-1];
   assign bus.full        = valid_q[NUM_ENTRIES-1];
   assign bus.nxt_valid   = nxt_valid_q;
   assign bus.intm_rs_out = out_q;

`ifdef INTM_RS_PERF_EN
   logic [31:0] perf_full_q;
   logic [31:0] perf_issued_q;
   logic [31:0] perf_stall_q;

   // Saturating counters; cleared by reset only.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_full_q   <= '0;
         perf_issued_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if (valid_q[NUM_ENTRIES-1] && (perf_full_q != '1))
            perf_full_q <= perf_full_q + 32'd1;
         if (do_issue && (perf_issued_q != '1))
            perf_issued_q <= perf_issued_q + 32'd1;
         if (nxt_valid_q && !bus.nxt_ready && (perf_stall_q != '1))
            perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign bus.perf_full_cycles  = perf_full_q;
   assign bus.perf_issued       = perf_issued_q;
   assign bus.perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_intm_rs.sv
// Bench for intm_rs: queue-level reference model checked every cycle, plus
// hand-computed expectations for the directed scenarios.
module tb_intm_rs;
   import intm_rs_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned CW = 3;

   logic clk = 1'b0;
   logic rst;

   intm_rs_if #(.CDB_WIDTH(CW)) bus ();

   intm_rs #(.NUM_ENTRIES(N), .CDB_WIDTH(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] prf_val(input logic [5:0] p);
      return {16'hA5A5, 2'b00, p, 2'b00, p};
   endfunction

   assign bus.prf_rs1_value = prf_val(bus.prf_rs1_phy);
   assign bus.prf_rs2_value = prf_val(bus.prf_rs2_phy);

   int n_vec = 0;
   int n_err = 0;
   int fired[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   intm_rs_entry_t mq[$];
   logic           m_nv  = 1'b0;
   intm_rs_reg_t   m_out = '0;

   function automatic logic on_cdb(input logic [5:0] phy);
      for (int k = 0; k < CW; k++) begin
         if (bus.cdb_valid[k] && (bus.cdb_rd_phy[k*6 +: 6] == phy)) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic intm_rs_entry_t woken(input intm_rs_entry_t e);
      intm_rs_entry_t r;
      r = e;
      r.rs1_rdy = e.rs1_rdy || (e.rs1_phy == 6'd0) || on_cdb(e.rs1_phy);
      r.rs2_rdy = e.rs2_rdy || (e.rs2_phy == 6'd0) || on_cdb(e.rs2_phy);
      return r;
   endfunction

   function automatic int oldest_ready();
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i].rs1_rdy && mq[i].rs2_rdy) return i;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      int  s;
      int  pre;
      logic adv;
      if (rst) begin
         mq.delete();
         m_nv  = 1'b0;
         m_out = '0;
      end else begin
         adv = !m_nv || bus.nxt_ready;
         s   = oldest_ready();
         pre = mq.size();
         if (bus.flush) begin
            mq.delete();
            m_nv = 1'b0;
         end else begin
            if (adv) begin
               if (s >= 0) begin
                  m_out.rob_id    = mq[s].rob_id;
                  m_out.rd_arch   = mq[s].rd_arch;
                  m_out.rd_phy    = mq[s].rd_phy;
                  m_out.rs1_value = prf_val(mq[s].rs1_phy);
                  m_out.rs2_value = prf_val(mq[s].rs2_phy);
                  m_out.fu_opcode = mq[s].fu_opcode;
                  m_nv = 1'b1;
                  mq.delete(s);
               end else begin
                  m_nv = 1'b0;
               end
            end
            foreach (mq[i]) mq[i] = woken(mq[i]);
            if (bus.dis_valid && (pre < N)) mq.push_back(woken(bus.dis_uop));
         end
      end
   end

   // Compare process, away from the active edge.
   always @(negedge clk) begin
      int s;
      logic [5:0] e1;
      logic [5:0] e2;
      if (!rst) begin
         s  = (!m_nv || bus.nxt_ready) ? oldest_ready() : -1;
         e1 = 6'd0;
         e2 = 6'd0;
         if (s >= 0) begin
            e1 = mq[s].rs1_phy;
            e2 = mq[s].rs2_phy;
         end
         chk("dis_ready",   128'(bus.dis_ready),   128'(mq.size() < N));
         chk("full",        128'(bus.full),        128'(mq.size() == N));
         chk("nxt_valid",   128'(bus.nxt_valid),   128'(m_nv));
         chk("prf_rs1_phy", 128'(bus.prf_rs1_phy), 128'(e1));
         chk("prf_rs2_phy", 128'(bus.prf_rs2_phy), 128'(e2));
         if (m_nv) chk("intm_rs_out", 128'(bus.intm_rs_out), 128'(m_out));
         if (bus.nxt_valid && bus.nxt_ready) fired.push_back(int'(bus.intm_rs_out.rob_id));
      end
   end

   // ---------------- stimulus ----------------
   function automatic intm_rs_entry_t mk(input int rob, input int s1, input logic r1,
                                         input int s2, input logic r2, input md_op_e op);
      intm_rs_entry_t e;
      e.rob_id    = 5'(rob);
      e.rd_arch   = 5'(rob + 1);
      e.rd_phy    = 6'(rob + 32);
      e.rs1_phy   = 6'(s1);
      e.rs1_rdy   = r1;
      e.rs2_phy   = 6'(s2);
      e.rs2_rdy   = r2;
      e.fu_opcode = op;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_fired(input string name, input int exp[$]);
      chk({name, "_count"}, 128'(fired.size()), 128'(exp.size()));
      for (int i = 0; i < exp.size() && i < fired.size(); i++) begin
         chk(name, 128'(fired[i]), 128'(exp[i]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst            = 1'b1;
      bus.flush      = 1'b0;
      bus.dis_valid  = 1'b0;
      bus.dis_uop    = '0;
      bus.cdb_valid  = '0;
      bus.cdb_rd_phy = '0;
      bus.nxt_ready  = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_dis_ready", 128'(bus.dis_ready),   128'(1));
      chk("rst_nxt_valid", 128'(bus.nxt_valid),   128'(0));
      chk("rst_full",      128'(bus.full),        128'(0));
      chk("rst_out",       128'(bus.intm_rs_out), 128'(0));

      // 1: both sources ready, issue two cycles after dispatch
      bus.dis_uop = mk(3, 5, 1'b1, 6, 1'b1, MD_MUL);
      bus.dis_valid = 1'b1;
      tick();
      bus.dis_valid = 1'b0;
      chk("t1_nv_c1", 128'(bus.nxt_valid), 128'(0));
      tick();
      chk("t1_nv_c2", 128'(bus.nxt_valid), 128'(1));
      chk("t1_rob",   128'(bus.intm_rs_out.rob_id),    128'(3));
      chk("t1_rs1v",  128'(bus.intm_rs_out.rs1_value), 128'(32'hA5A5_0505));
      chk("t1_rs2v",  128'(bus.intm_rs_out.rs2_value), 128'(32'hA5A5_0606));
      tick();

      // 2: younger ready uop overtakes; CDB wakes the older one
      fired.delete();
      bus.dis_uop = mk(1, 7, 1'b0, 6, 1'b1, MD_DIV);
      bus.dis_valid = 1'b1;
      tick();
      bus.dis_uop = mk(2, 5, 1'b1, 6, 1'b1, MD_MULH);
      tick();
      bus.dis_valid = 1'b0;
      tick();
      chk("t2_rob2", 128'(bus.intm_rs_out.rob_id), 128'(2));
      bus.cdb_valid  = 3'b001;
      bus.cdb_rd_phy = {6'd0, 6'd0, 6'd7};
      tick();
      bus.cdb_valid = '0;
      chk("t2_gap", 128'(bus.nxt_valid), 128'(0));
      tick();
      chk("t2_nv",   128'(bus.nxt_valid), 128'(1));
      chk("t2_rob1", 128'(bus.intm_rs_out.rob_id), 128'(1));
      tick();
      chk_fired("t2_order", '{2, 1});

      // 3: fill, reject while full (also during issue), compaction keeps age
      fired.delete();
      for (int k = 0; k < 4; k++) begin
         bus.dis_uop = mk(10 + k, 10 + k, 1'b0, 0, 1'b0, MD_DIVU);
         bus.dis_valid = 1'b1;
         tick();
      end
      bus.dis_valid = 1'b0;
      chk("t3_full",   128'(bus.full),      128'(1));
      chk("t3_dis_rd", 128'(bus.dis_ready), 128'(0));
      bus.cdb_valid  = 3'b100;
      bus.cdb_rd_phy = {6'd12, 6'd0, 6'd0};
      bus.dis_uop    = mk(14, 1, 1'b1, 2, 1'b1, MD_MUL);
      bus.dis_valid  = 1'b1;
      tick();
      bus.cdb_valid = '0;
      bus.dis_uop   = mk(15, 1, 1'b1, 2, 1'b1, MD_MUL);
      chk("t3_full_w", 128'(bus.full), 128'(1));
      tick();
      bus.dis_valid = 1'b0;
      chk("t3_full_drop", 128'(bus.full), 128'(0));
      chk("t3_rob12",     128'(bus.intm_rs_out.rob_id), 128'(12));
      bus.cdb_valid  = 3'b111;
      bus.cdb_rd_phy = {6'd13, 6'd11, 6'd10};
      tick();
      bus.cdb_valid = '0;
      repeat (4) tick();
      chk_fired("t3_order", '{12, 10, 11, 13});

      // 4: stall holds the issue register, then back-to-back in age order
      fired.delete();
      bus.nxt_ready = 1'b0;
      bus.dis_uop = mk(20, 3, 1'b1, 4, 1'b1, MD_REM);
      bus.dis_valid = 1'b1;
      tick();
      bus.dis_uop = mk(21, 4, 1'b1, 3, 1'b1, MD_REMU);
      tick();
      bus.dis_valid = 1'b0;
      repeat (5) tick();
      chk("t4_hold",   128'(bus.intm_rs_out.rob_id),    128'(20));
      chk("t4_hold_v", 128'(bus.intm_rs_out.rs2_value), 128'(32'hA5A5_0404));
      bus.nxt_ready = 1'b1;
      tick();
      chk("t4_rob21", 128'(bus.intm_rs_out.rob_id), 128'(21));
      tick();
      chk_fired("t4_order", '{20, 21});

      // 5: wakeup in the dispatch cycle
      fired.delete();
      bus.dis_uop    = mk(5, 5, 1'b1, 9, 1'b0, MD_REM);
      bus.dis_valid  = 1'b1;
      bus.cdb_valid  = 3'b010;
      bus.cdb_rd_phy = {6'd0, 6'd9, 6'd0};
      tick();
      bus.dis_valid = 1'b0;
      bus.cdb_valid = '0;
      tick();
      chk("t5_nv",   128'(bus.nxt_valid), 128'(1));
      chk("t5_rob",  128'(bus.intm_rs_out.rob_id),    128'(5));
      chk("t5_rs2v", 128'(bus.intm_rs_out.rs2_value), 128'(32'hA5A5_0909));
      tick();

      // 6: flush with held issue register, 3 entries and a dispatch
      fired.delete();
      bus.nxt_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.dis_uop = mk(25 + k, 1, 1'b1, 2, 1'b1, MD_DIV);
         bus.dis_valid = 1'b1;
         tick();
      end
      chk("t6_pre_nv", 128'(bus.nxt_valid), 128'(1));
      bus.dis_uop   = mk(29, 1, 1'b1, 2, 1'b1, MD_DIV);
      bus.dis_valid = 1'b1;
      bus.flush     = 1'b1;
      tick();
      bus.dis_valid = 1'b0;
      bus.flush     = 1'b0;
      chk("t6_nv",    128'(bus.nxt_valid), 128'(0));
      chk("t6_full",  128'(bus.full),      128'(0));
      chk("t6_dis_r", 128'(bus.dis_ready), 128'(1));
      bus.nxt_ready = 1'b1;
      repeat (5) tick();
      chk("t6_no_issue", 128'(fired.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
